counter_share_ctrl: RTL and testbench

Controller that shares one 4-bit up-counter (a timer resource) among NUM_REQ requesters.
- Each requester asks for a count window of a given length.
- The block arbitrates round-robin and grants exactly one requester at a time.
- It drives the counter enable and clear, and signals completion per requester.
- It sits between client blocks and the counter datapath. The counter is instantiated inside this block.

---
 rtl/counter_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 44 ++++
 rtl/counter_share_ctrl.sv | 131 +++++++++++++
 tb/tb_counter_share_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared state encodings and default sizes for the counter share controller
package counter_pkg;

    localparam int DEF_CNT_W   = 4;
    localparam int DEF_NUM_REQ = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at ptr_i, with index encoder
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [PTR_W-1:0]   idx_o,
    output logic               valid_o
);

    logic [NUM_REQ-1:0] pick;

    // Walk from ptr_i upward with wrap; the first set request wins.
    always_comb begin
        logic [PTR_W:0] pos;
        logic           found;
        pick  = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = {1'b0, ptr_i} + (PTR_W+1)'(k);
            if (pos >= (PTR_W+1)'(NUM_REQ)) begin
                pos = pos - (PTR_W+1)'(NUM_REQ);
            end
            if (!found && req_i[pos[PTR_W-1:0]]) begin
                pick[pos[PTR_W-1:0]] = 1'b1;
                found                = 1'b1;
            end
        end
    end

    always_comb begin
        idx_o = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (pick[k]) begin
                idx_o = PTR_W'(k);
            end
        end
    end

    assign valid_o = |pick;

endmodule

// File: rtl/counter_share_ctrl.sv
// rtl/counter_share_ctrl.sv - round-robin sharing of one up-counter window; TIMER_ABORT_EN adds abort/aborted
module counter_share_ctrl
    import counter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*CNT_W-1:0] len,
`ifdef TIMER_ABORT_EN
    input  logic                     abort,
    output logic                     aborted,
`endif
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy,
    output logic                     cnt_en,
    output logic [CNT_W-1:0]         cnt_value
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   sel_q, sel_d;
    logic [CNT_W-1:0]   len_l_q, len_l_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]   arb_idx;
    logic               arb_valid;
    logic               abort_w;
    logic [NUM_REQ-1:0] sel_oh;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

`ifdef TIMER_ABORT_EN
    logic aborted_q, aborted_d;

    assign abort_w = abort;

    // Flag set on the RUN->DONE edge caused by abort; cleared when DONE retires.
    always_comb begin
        aborted_d = aborted_q;
        if (state_q == ST_RUN && abort && cnt_q != len_l_q) begin
            aborted_d = 1'b1;
        end else if (state_q == ST_DONE) begin
            aborted_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= aborted_d;
        end
    end

    assign aborted = aborted_q;
`else
    assign abort_w = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        len_l_d = len_l_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (arb_valid) begin
                    sel_d   = arb_idx;
                    len_l_d = len[arb_idx*CNT_W +: CNT_W];
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Completion takes precedence over abort; counter holds in both cases.
                if (cnt_q == len_l_q || abort_w) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                ptr_d   = (sel_q == PTR_W'(NUM_REQ-1)) ? '0 : sel_q + 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            len_l_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            len_l_q <= len_l_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sel_oh    = {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_q;
    assign gnt       = (state_q != ST_IDLE) ? sel_oh : '0;
    assign done      = (state_q == ST_DONE) ? sel_oh : '0;
    assign busy      = (state_q != ST_IDLE);
    assign cnt_en    = (state_q == ST_RUN);
    assign cnt_value = cnt_q;

endmodule

// File: tb/tb_counter_share_ctrl.sv
// tb/tb_counter_share_ctrl.sv - scoreboard bench for counter_share_ctrl (abort case under TIMER_ABORT_EN)
module tb_counter_share_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] len;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        busy;
    logic        cnt_en;
    logic [3:0]  cnt_value;
`ifdef TIMER_ABORT_EN
    logic        abort;
    logic        aborted;
`endif

    counter_share_ctrl #(.NUM_REQ(4), .CNT_W(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .len       (len),
`ifdef TIMER_ABORT_EN
        .abort     (abort),
        .aborted   (aborted),
`endif
        .gnt       (gnt),
        .done      (done),
        .busy      (busy),
        .cnt_en    (cnt_en),
        .cnt_value (cnt_value)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] gnt;
        logic [3:0] done;
        logic [3:0] cnt;
        logic       ab;
        logic       en;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;
    bit   prev_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act === expv) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    endtask

    // Expected busy-cycle trace of one window: RUN cycles with count c, then DONE.
    // cut truncates the trace (reset mid-run); ab_at ends RUN early via abort.
    task automatic push_window(input int idx, input int l, input int cut, input int ab_at);
        logic [3:0] oh;
        oh = 4'b0001 << idx;
        for (int c = 0; c <= l; c++) begin
            if (c == cut) return;
            exp_q.push_back('{gnt: oh, done: 4'b0, cnt: 4'(c), ab: 1'b0, en: 1'b1});
            if (c == ab_at) begin
                exp_q.push_back('{gnt: oh, done: oh, cnt: 4'(c), ab: 1'b1, en: 1'b0});
                return;
            end
        end
        exp_q.push_back('{gnt: oh, done: oh, cnt: 4'(l), ab: 1'b0, en: 1'b0});
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (prev_done) chk("idle_gap_busy", {31'b0, busy}, 32'd0);
        prev_done = |done;
        if (busy) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_grant", {28'b0, gnt}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("gnt", {28'b0, gnt}, {28'b0, e.gnt});
                chk("done", {28'b0, done}, {28'b0, e.done});
                chk("cnt_value", {28'b0, cnt_value}, {28'b0, e.cnt});
                chk("cnt_en", {31'b0, cnt_en}, {31'b0, e.en});
`ifdef TIMER_ABORT_EN
                chk("aborted", {31'b0, aborted}, {31'b0, e.ab});
`endif
            end
        end else begin
            chk("idle_done", {28'b0, done}, 32'd0);
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clock);
        while (busy && n < 60) begin
            @(negedge clock);
            n++;
        end
        chk("wait_idle_timeout", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        req   = 4'b1111;
        len   = 16'h0000;
`ifdef TIMER_ABORT_EN
        abort = 1'b0;
`endif
        repeat (5) @(posedge clock);
        #1;
        chk("rst_gnt", {28'b0, gnt}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_cnt", {28'b0, cnt_value}, 32'd0);

        // Requester 0 wins first after reset release
        push_window(0, 0, -1, -1);
        @(negedge clock) reset = 1'b1;
        @(posedge clock); #1 req = 4'b0000;
        wait_idle();

        // Single window, len[2]=3: cnt 0,1,2,3,3
        push_window(2, 3, -1, -1);
        len = 16'h0300;
        req = 4'b0100;
        @(posedge clock); #1 req = 4'b0000;
        wait_idle();

        @(negedge clock) reset = 1'b0;
        @(negedge clock) reset = 1'b1;

        // Round-robin from pointer 0: 0,1,3,0
        len = 16'h1111;
        push_window(0, 1, -1, -1);
        push_window(1, 1, -1, -1);
        push_window(3, 1, -1, -1);
        push_window(0, 1, -1, -1);
        req = 4'b1011;
        repeat (14) @(posedge clock);
        #1 req = 4'b0000;
        wait_idle();

        // len=0 with request dropped after grant: no re-grant
        len = 16'h0000;
        push_window(1, 0, -1, -1);
        req = 4'b0010;
        @(posedge clock); #1 req = 4'b0000;
        wait_idle();
        repeat (4) @(negedge clock);

        // Async reset at cnt_value=2 aborts the window without done
        len = 16'h5000;
        push_window(3, 5, 3, -1);
        req = 4'b1000;
        @(posedge clock); #1 req = 4'b0000;
        repeat (2) @(posedge clock);
        @(negedge clock);
        #2;
        chk("pre_reset_cnt", {28'b0, cnt_value}, 32'd2);
        reset = 1'b0;
        #1;
        chk("mid_rst_gnt", {28'b0, gnt}, 32'd0);
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        chk("mid_rst_cnt", {28'b0, cnt_value}, 32'd0);
        chk("mid_rst_done", {28'b0, done}, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;

        // Pointer restarts at 0: requester 0 beats 2
        len = 16'h0000;
        push_window(0, 0, -1, -1);
        req = 4'b0101;
        @(posedge clock); #1 req = 4'b0000;
        wait_idle();

`ifdef TIMER_ABORT_EN
        len = 16'h000A;
        push_window(0, 10, -1, 4);
        req = 4'b0001;
        @(posedge clock); #1 req = 4'b0000;
        repeat (4) @(posedge clock);
        #1 abort = 1'b1;
        @(posedge clock); #1 abort = 1'b0;
        wait_idle();
`endif

        repeat (3) @(negedge clock);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

endmodule
